// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB-Lite memory responder: transfer codes,
// transfer sizes, response codes, responder FSM states and byte-lane helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } resp_state_t;

    // Sizes above word fall into the default arm and behave as word accesses.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << lo;
            HSIZE_HALF: byte_lanes = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_lanes = 4'b1111;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: misaligned = 1'b0;
            HSIZE_HALF: misaligned = lo[0];
            default:    misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/ahb_resp_sram.sv
// Word-organised storage for the responder: byte-enable write on the clock edge,
// asynchronous read from the same index. Contents are never reset.
module ahb_resp_sram #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder with programmable wait states and byte-writable storage.
// Optional AHB_RESP_ERR_EN adds ERROR responses for out-of-range or misaligned transfers.
//
// state | meaning
// IDLE  | no data phase in progress
// WAIT  | data phase stalled, HREADY low, wait counter running down
// DATA  | data phase completes this cycle (read data out / write commits)
// ERR1  | first ERROR cycle, HREADY low
// ERR2  | second ERROR cycle, HREADY high
module ahb_mem_responder
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    resp_state_t       state_q;
    logic              hready_q;
    logic              hresp_q;
    logic              write_q;
    logic [2:0]        wcnt_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        be_q, be_d;
    logic              accept;
    logic              err_d;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    assign accept = HSEL && hready_q &&
                    (htrans_t'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign idx_d  = HADDR[2 +: IDX_W];
    assign be_d   = byte_lanes(HSIZE, HADDR[1:0]);

`ifdef AHB_RESP_ERR_EN
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS) << 2;
    assign err_d = (HADDR >= ADDR_LIMIT) || misaligned(HSIZE, HADDR[1:0]);
`else
    // Upper address bits are ignored so the index wraps modulo the depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^HADDR[ADDR_W-1:2+IDX_W];
    assign err_d          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            wcnt_q   <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            be_q     <= '0;
        end else begin
            if (accept) begin
                idx_q   <= idx_d;
                be_q    <= be_d;
                write_q <= HWRITE;
            end
            unique case (state_q)
                ST_WAIT: begin
                    if (wcnt_q == 3'd0) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all have HREADY high, so a new transfer may start.
                    if (!accept) begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end else if (err_d) begin
                        state_q  <= ST_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state_q  <= ST_WAIT;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_OKAY;
                        wcnt_q   <= WAIT_LAST;
                    end else begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign mem_we = (state_q == ST_DATA) && write_q && !rst;

    ahb_resp_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (idx_q),
        .be_i    (be_q),
        .wdata_i (HWDATA),
        .rdata_o (rd_word)
    );

    assign HRDATA = (state_q == ST_DATA && !write_q) ? rd_word : '0;
    assign HREADY = hready_q;
    assign HRESP  = hresp_q;

endmodule
